// File: rtl/result_uart_tx.sv
// result_uart_tx: return path of the FPGA miner.
// Latches the winning nonce and 256-bit hash on a found pulse and sends them
// to the host as one framed byte stream on a UART 8N1 transmit line:
//   SYNC_BYTE, nonce MSB byte first, hash MSB byte first.
// Optional feature macro: RESULT_TX_CHECKSUM_EN appends one extra byte holding
// the XOR of all nonce and hash bytes (sync byte excluded).
// Outputs are registered from the current FSM state, so the line changes one
// clock after the state does; tx falls on the edge after found is sampled.

module result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         found,
  input  logic [31:0]  nonce,
  input  logic [255:0] hash,
  output logic         tx,
  output logic         busy,
  output logic         done,
  output logic         overrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef RESULT_TX_CHECKSUM_EN
  localparam logic [5:0] LAST_BYTE = 6'd37;
`else
  localparam logic [5:0] LAST_BYTE = 6'd36;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    NEXT
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [5:0]     byte_idx;
  logic [295:0]   frame;
  logic [7:0]     cur_byte;

`ifdef RESULT_TX_CHECKSUM_EN
  logic [7:0]     csum;
`endif

  // The byte on the wire is always the top byte of the frame register; the
  // register shifts up by one byte after every stop bit.
  assign cur_byte = frame[295:288];

`ifdef RESULT_TX_CHECKSUM_EN
  // Running XOR of the payload bytes, cleared when a frame starts and folded
  // in as each nonce/hash byte moves to the top of the frame register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      csum <= 8'h00;
    end else if (state == IDLE && found) begin
      csum <= 8'h00;
    end else if (state == NEXT && byte_idx < 6'd36) begin
      csum <= csum ^ frame[287:280];
    end
  end
`endif

  // Sticky overrun: any find that arrives while the FSM is not in IDLE is
  // dropped, including one that lands on the final NEXT cycle of a frame.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overrun <= 1'b0;
    end else if (found && state != IDLE) begin
      overrun <= 1'b1;
    end
  end

  // Transmit FSM: bit timing, byte sequencing and the registered line/status outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 6'd0;
      frame    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (found) begin
            frame    <= {SYNC_BYTE, nonce, hash};
            byte_idx <= 6'd0;
            bit_idx  <= 3'd0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= START;
          end
        end

        START: begin
          tx <= 1'b0;
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          tx <= cur_byte[bit_idx];
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          tx <= 1'b1;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= NEXT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        NEXT: begin
          tx <= 1'b1;
          if (byte_idx == LAST_BYTE) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            byte_idx <= byte_idx + 6'd1;
`ifdef RESULT_TX_CHECKSUM_EN
            if (byte_idx == 6'd36) begin
              frame <= {csum, 288'd0};
            end else begin
              frame <= {frame[287:0], 8'h00};
            end
`else
            frame <= {frame[287:0], 8'h00};
`endif
            state <= START;
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// tb_result_uart_tx: directed bench for result_uart_tx with CLKS_PER_BIT=4.
// Expected frame bytes are pushed to a scoreboard queue when a find is driven;
// a clocked UART receiver decodes the line and pops/compares each byte.
// Honours RESULT_TX_CHECKSUM_EN so the same bench covers both builds.
`timescale 1ns/1ps

module tb_result_uart_tx;

  localparam int CPB = 4;
`ifdef RESULT_TX_CHECKSUM_EN
  localparam int NB = 38;
`else
  localparam int NB = 37;
`endif
  localparam int FRAME_CYC = NB * (10 * CPB + 1);

  logic         clock;
  logic         resetn;
  logic         found;
  logic [31:0]  nonce;
  logic [255:0] hash;
  logic         tx;
  logic         busy;
  logic         done;
  logic         overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_pulses = 0;

  logic [7:0] exp_q[$];

  bit         d_active = 1'b0;
  int         d_cnt    = 0;
  logic [7:0] d_shift  = 8'h00;

  result_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clock   (clock),
    .resetn  (resetn),
    .found   (found),
    .nonce   (nonce),
    .hash    (hash),
    .tx      (tx),
    .busy    (busy),
    .done    (done),
    .overrun (overrun)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Cycle counter used for latency and frame-length measurements.
  always @(posedge clock) cyc <= cyc + 1;

  // Counts every cycle in which done is seen high.
  always @(negedge clock) if (done === 1'b1) done_pulses <= done_pulses + 1;

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // UART receiver: offset 0 is the first negedge with tx low; each bit is
  // sampled at its middle (offset k*CPB + CPB/2) away from the driving edge.
  always @(negedge clock) begin
    if (!resetn) begin
      d_active <= 1'b0;
      d_cnt    <= 0;
    end else if (!d_active) begin
      if (tx === 1'b0) begin
        d_active <= 1'b1;
        d_cnt    <= 1;
      end
    end else begin
      d_cnt <= d_cnt + 1;
      if (d_cnt == CPB / 2) begin
        checkOutput("start_bit", {63'd0, tx}, 64'd0);
      end else if (d_cnt > CPB / 2 && d_cnt < 9 * CPB && (d_cnt % CPB) == CPB / 2) begin
        d_shift <= {tx, d_shift[7:1]};
      end else if (d_cnt == 9 * CPB + CPB / 2) begin
        checkOutput("stop_bit", {63'd0, tx}, 64'd1);
        checkOutput("byte_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) checkOutput("rx_byte", {56'd0, d_shift}, {56'd0, exp_q.pop_front()});
        d_active <= 1'b0;
      end
    end
  end

  function automatic logic [255:0] randHash();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Drive a one-cycle find; when the DUT should accept it, push the frame the
  // receiver must see. Returns on the negedge after the sampling edge.
  task automatic applyStimulus(input logic [31:0] n, input logic [255:0] h, input bit accept);
`ifdef RESULT_TX_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
`endif
    found = 1'b1;
    nonce = n;
    hash  = h;
    if (accept) begin
      exp_q.push_back(8'hA5);
      for (int i = 3; i >= 0; i--) begin
        exp_q.push_back(n[i*8 +: 8]);
`ifdef RESULT_TX_CHECKSUM_EN
        x ^= n[i*8 +: 8];
`endif
      end
      for (int i = 31; i >= 0; i--) begin
        exp_q.push_back(h[i*8 +: 8]);
`ifdef RESULT_TX_CHECKSUM_EN
        x ^= h[i*8 +: 8];
`endif
      end
`ifdef RESULT_TX_CHECKSUM_EN
      exp_q.push_back(x);
`endif
    end
    @(negedge clock);
    found = 1'b0;
    nonce = $urandom();
    hash  = randHash();
  endtask

  // Latency: busy up and tx still idle right after the sampling edge, tx low one edge later.
  task automatic checkLaunch(input string tag, output int t_fall);
    checkOutput({tag, "_busy_set"}, {63'd0, busy}, 64'd1);
    checkOutput({tag, "_tx_hold"}, {63'd0, tx}, 64'd1);
    @(negedge clock);
    checkOutput({tag, "_tx_fall"}, {63'd0, tx}, 64'd0);
    t_fall = cyc;
  endtask

  // Wait (bounded) for done; frame length counts from the first start-bit cycle
  // through the done cycle inclusive.
  task automatic waitDone(input string tag, input int t_fall);
    int   n;
    bit   seen;
    logic pb;
    n = 0;
    seen = 1'b0;
    pb = busy;
    while (!seen && n < FRAME_CYC + 100) begin
      pb = busy;
      @(negedge clock);
      n++;
      seen = (done === 1'b1);
    end
    checkOutput({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
    checkOutput({tag, "_frame_cycles"}, 64'(cyc - t_fall + 1), 64'(FRAME_CYC));
    checkOutput({tag, "_busy_drop"}, {63'd0, busy}, 64'd0);
    checkOutput({tag, "_busy_before"}, {63'd0, pb}, 64'd1);
    checkOutput({tag, "_all_bytes"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int t_fall;
    int dp;
    int bad;

    resetn = 1'b0;
    found  = 1'b0;
    nonce  = 32'd0;
    hash   = 256'd0;

    // Reset state and a long idle stretch with no finds.
    repeat (3) @(negedge clock);
    checkOutput("rst_tx", {63'd0, tx}, 64'd1);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_overrun", {63'd0, overrun}, 64'd0);
    #2 resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) bad++;
    end
    checkOutput("idle_1000", 64'(bad), 64'd0);

    // Single frame with the reference nonce/hash.
    $display("[TB] single frame");
    applyStimulus(32'h42a14695,
                  256'h00000000000000001e8d6829a8a21adc5d38d0a473b144b6765798e61f98bd1d, 1'b1);
    checkLaunch("f1", t_fall);
    dp = done_pulses;
    waitDone("f1", t_fall);
    @(negedge clock);
    checkOutput("f1_done_width", {63'd0, done}, 64'd0);
    repeat (50) @(negedge clock);
    checkOutput("f1_done_once", 64'(done_pulses - dp), 64'd1);
    checkOutput("f1_no_overrun", {63'd0, overrun}, 64'd0);

    // Overrun: a second find 100 cycles into a frame is dropped.
    $display("[TB] overrun");
    applyStimulus(32'h1234abcd, randHash(), 1'b1);
    checkLaunch("f2", t_fall);
    repeat (100) @(negedge clock);
    applyStimulus(32'hFFFFFFFF, randHash(), 1'b0);
    checkOutput("ovr_set", {63'd0, overrun}, 64'd1);
    checkOutput("ovr_busy", {63'd0, busy}, 64'd1);
    waitDone("f2", t_fall);
    repeat (5) @(negedge clock);
    checkOutput("ovr_sticky", {63'd0, overrun}, 64'd1);
    checkOutput("ovr_idle_tx", {63'd0, tx}, 64'd1);

    // Reset asserted during a data bit of byte 10.
    $display("[TB] reset mid-frame");
    applyStimulus(32'hdeadbeef, randHash(), 1'b1);
    checkLaunch("f3", t_fall);
    repeat (10 * (10 * CPB + 1) + 9) @(negedge clock);
    dp = done_pulses;
    #2 resetn = 1'b0;
    #1;
    checkOutput("mid_rst_tx", {63'd0, tx}, 64'd1);
    checkOutput("mid_rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("mid_rst_overrun", {63'd0, overrun}, 64'd0);
    exp_q.delete();
    repeat (5) @(negedge clock);
    #2 resetn = 1'b1;
    repeat (60) @(negedge clock);
    checkOutput("mid_rst_no_done", 64'(done_pulses - dp), 64'd0);
    checkOutput("mid_rst_tx_idle", {63'd0, tx}, 64'd1);

    // Full frame after the reset, then a back-to-back find right after done.
    $display("[TB] post-reset and back-to-back");
    applyStimulus(32'h0badf00d, randHash(), 1'b1);
    checkLaunch("f4", t_fall);
    waitDone("f4", t_fall);
    applyStimulus(32'hcafe0001, randHash(), 1'b1);
    checkLaunch("f5", t_fall);
    checkOutput("b2b_no_overrun", {63'd0, overrun}, 64'd0);
    waitDone("f5", t_fall);
    checkOutput("b2b_overrun_end", {63'd0, overrun}, 64'd0);

`ifdef RESULT_TX_CHECKSUM_EN
    // Checksum byte for nonce 01020304 with zero hash is 04.
    $display("[TB] checksum frame");
    repeat (3) @(negedge clock);
    applyStimulus(32'h01020304, 256'd0, 1'b1);
    checkLaunch("f6", t_fall);
    waitDone("f6", t_fall);
`endif

    repeat (10) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Return path of the FPGA miner. The miner control block consumes a 640-bit block header and produces a satisfactory hash; this block reports that result to the host.
- It latches the winning nonce and 256-bit hash when the miner signals a find.
- It then serialises them as a framed byte stream over a UART 8N1 transmit line.
- It sits between the miner control block and the board's UART TX pin.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); legal range 2 to 65535.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clock  input  1  system clock, rising-edge.
- resetn  input  1  asynchronous active-low reset.
- found  input  1  one-cycle pulse: nonce/hash valid this cycle.
- nonce  input  32  winning nonce, sampled when found=1.
- hash  input  256  satisfactory hash, sampled when found=1.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high while a frame is in flight.
- done  output  1  one-cycle pulse after the final stop bit of a frame.
- overrun  output  1  sticky flag: a find was dropped because the block was busy.

Behaviour:
- Reset (async, resetn=0): tx=1, busy=0, done=0, overrun=0, FSM=IDLE, all counters and shift registers cleared. Reset asserted mid-frame aborts the frame immediately; tx returns high in the same cycle and no done pulse is produced.
- Frame bytes, in order:
  - SYNC_BYTE.
  - nonce[31:24], nonce[23:16], nonce[15:8], nonce[7:0].
  - hash[255:248] down to hash[7:0] (32 bytes, MSB byte first).
  - Total 37 bytes (38 with the optional feature).
- Byte encoding: start bit 0, data bits LSB first, stop bit 1. Each bit is held for exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP, NEXT.
  - IDLE: tx=1. When found=1 at a clock edge: latch nonce/hash into a 296-bit frame register, load byte index 0, set busy=1, go to START.
  - START: drive tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: drive the current bit for CLKS_PER_BIT cycles. Advance the bit index; after bit 7 go to STOP.
  - STOP: drive tx=1 for CLKS_PER_BIT cycles, then go to NEXT.
  - NEXT (1 cycle, tx=1):
    - If the byte index is at the last byte: busy=0, done=1 for this cycle, go to IDLE.
    - Otherwise: increment the byte index and go to START.
- Latency: tx falls on the first clock edge after the edge that samples found.
- Frame duration: 37×(10×CLKS_PER_BIT+1) cycles from the start bit to done.
- found while busy=1: ignored; frame contents are unaffected; overrun set to 1 and held until reset.
- found in the same cycle as NEXT→IDLE: ignored; overrun set. A new frame is accepted only when the FSM is in IDLE.
- The bit-period counter is ceil(log2(CLKS_PER_BIT)) bits wide and counts 0..CLKS_PER_BIT-1. The byte index is 6 bits.
- nonce/hash inputs may change freely after the sampling edge; only the latched copy is transmitted.

Optional Feature:
- Macro: RESULT_TX_CHECKSUM_EN.
- Defined: a 38th byte is appended, equal to the XOR of the 36 nonce and hash bytes (SYNC_BYTE excluded). It is accumulated in a register as each byte is loaded for transmission, and cleared on frame start.
  - done fires after this byte's stop bit.
  - Frame duration becomes 38×(10×CLKS_PER_BIT+1) cycles.
- Undefined: no checksum register exists; the frame is 37 bytes.

Test Plan:
- Reset idle: resetn=0 then 1, no found → tx=1, busy=0, done=0, overrun=0 for 1000 cycles.
- Single frame, CLKS_PER_BIT=4:
  - Stimulus: found pulse with nonce=32'h42a14695, hash=256'h00000000000000001e8d6829a8a21adc5d38d0a473b144b6765798e61f98bd1d.
  - Required: the bench UART decoder recovers bytes A5,42,A1,46,95,00×8,1E,8D,…,BD,1D.
  - Required: done pulses once, exactly 37×41=1517 cycles after tx first falls; busy drops in the same cycle.
- Overrun: CLKS_PER_BIT=4; a second found with nonce=32'hFFFFFFFF arrives 100 cycles into a frame → transmitted nonce bytes remain those of the first frame; overrun=1 and stays 1 after done.
- Reset mid-frame: assert resetn=0 during a DATA bit of byte 10 → tx=1 and busy=0 asynchronously; no done. After release, a new found transmits a full correct frame.
- Checksum (RESULT_TX_CHECKSUM_EN defined): nonce=32'h01020304, hash=0 → 38th byte is 8'h04; done occurs 38×41=1558 cycles after the first start bit.
- Back-to-back: a second found issued the cycle after done → accepted; the second frame starts with no overrun; both frames decode correctly.
